cmos_frame_align: RTL and testbench

Parametrised CMOS capture front end in the cmos_pclk domain, placed between the sensor pins and the frame-write path of the video send chain.
- Delays href and data by a configurable number of stages.
- Detects frame start on a selectable vsync polarity and emits a one-cycle pulse.
- Drops the partial frame after reset and decimates frames by a fixed ratio.
- Reports per-line pixel count and per-frame line count for resolution checking.

---
 rtl/cmos_frame_align.sv | 208 ++++++++++++++++++++
 tb/tb_cmos_frame_align.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_frame_align.sv
// -----------------------------------------------------------------------------
// cmos_frame_align
//
// CMOS sensor capture front end, running entirely in the cmos_pclk domain.
// It sits between the sensor pins and the frame-write path and:
//   * delays href and pixel data by DELAY register stages,
//   * detects frame start on the selected vsync polarity and emits a
//     one-cycle pulse for every kept frame,
//   * drops the partial frame seen after reset and decimates frames by
//     keeping one frame, then dropping FRAME_SKIP frames,
//   * measures pixels per line and lines per frame for resolution checks.
//
// Ports
//   cmos_pclk        in   1       pixel clock (only clock)
//   rst              in   1       asynchronous, active-high reset
//   cmos_href        in   1       line valid from sensor
//   cmos_vsync       in   1       frame sync from sensor
//   cmos_data        in   DATA_W  pixel data
//   cmos_href_delay  out  1       delayed href, forced low in dropped frames
//   cmos_data_delay  out  DATA_W  delayed data, never gated
//   vsync_pulse      out  1       one-cycle pulse at start of each kept frame
//   frame_valid      out  1       high while the current frame is kept
//   pix_cnt          out  CNT_W   href-high cycles so far in current line
//   line_cnt         out  CNT_W   completed lines in current frame
//   line_len         out  CNT_W   pixel count of last completed line
//   frame_lines      out  CNT_W   line count of last completed frame
// -----------------------------------------------------------------------------
module cmos_frame_align #(
    parameter int DATA_W     = 16,
    parameter int DELAY      = 2,
    parameter int VS_POL     = 1,
    parameter int FRAME_SKIP = 0,
    parameter int CNT_W      = 12
) (
    input  logic              cmos_pclk,
    input  logic              rst,
    input  logic              cmos_href,
    input  logic              cmos_vsync,
    input  logic [DATA_W-1:0] cmos_data,
    output logic              cmos_href_delay,
    output logic [DATA_W-1:0] cmos_data_delay,
    output logic              vsync_pulse,
    output logic              frame_valid,
    output logic [CNT_W-1:0]  pix_cnt,
    output logic [CNT_W-1:0]  line_cnt,
    output logic [CNT_W-1:0]  line_len,
    output logic [CNT_W-1:0]  frame_lines
);

    // Skip counter needs at least one bit even when every frame is kept.
    localparam int                SKIP_W    = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP + 1) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(FRAME_SKIP);
    localparam logic              POL       = (VS_POL != 0);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    // Saturating increment shared by the pixel and line counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DELAY-1:0]             href_pipe_q, href_pipe_d;
    logic [DELAY-1:0][DATA_W-1:0] data_pipe_q, data_pipe_d;

    logic              v0_q, v0_d;
    logic              v1_q, v1_d;

    logic              armed_q, armed_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic              frame_valid_q, frame_valid_d;
    logic              vsync_pulse_q, vsync_pulse_d;

    logic              hd_prev_q, hd_prev_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]  line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0]  line_len_q, line_len_d;
    logic [CNT_W-1:0]  frame_lines_q, frame_lines_d;

    logic              hd;        // ungated href at the end of the delay line
    logic              vs_edge;   // frame-start edge seen on synchronised vsync
    logic              line_end;  // falling edge of hd

    // -------------------------------------------------------------------------
    // href / data delay line
    // -------------------------------------------------------------------------
    always_comb begin
        href_pipe_d    = '0;
        data_pipe_d    = '0;
        href_pipe_d[0] = cmos_href;
        data_pipe_d[0] = cmos_data;
        for (int i = 1; i < DELAY; i++) begin
            href_pipe_d[i] = href_pipe_q[i-1];
            data_pipe_d[i] = data_pipe_q[i-1];
        end
    end

    assign hd = href_pipe_q[DELAY-1];

    // -------------------------------------------------------------------------
    // vsync edge detection
    // -------------------------------------------------------------------------
    assign v0_d    = cmos_vsync;
    assign v1_d    = v0_q;
    assign vs_edge = (v0_q == POL) && (v1_q != POL);

    // -------------------------------------------------------------------------
    // Frame selection: the first edge after reset always starts a kept frame,
    // afterwards one frame in every FRAME_SKIP+1 is kept.
    // -------------------------------------------------------------------------
    always_comb begin
        armed_d       = armed_q;
        skip_cnt_d    = skip_cnt_q;
        frame_valid_d = frame_valid_q;
        vsync_pulse_d = 1'b0;
        if (vs_edge) begin
            if (!armed_q) begin
                armed_d       = 1'b1;
                skip_cnt_d    = '0;
                frame_valid_d = 1'b1;
            end else begin
                skip_cnt_d    = (skip_cnt_q == SKIP_LAST) ? '0 : skip_cnt_q + SKIP_W'(1);
                frame_valid_d = (skip_cnt_d == '0);
            end
            vsync_pulse_d = frame_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Resolution counters: run in every frame, kept or dropped.
    // A line ending on the same cycle as a frame edge is still counted into
    // the frame it belongs to before the counters clear.
    // -------------------------------------------------------------------------
    assign line_end  = !hd && hd_prev_q;
    assign hd_prev_d = hd;

    always_comb begin
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        if (vs_edge) begin
            if (line_end) begin
                line_len_d    = pix_cnt_q;
                frame_lines_d = sat_inc(line_cnt_q);
            end else begin
                frame_lines_d = line_cnt_q;
            end
            line_cnt_d = '0;
            pix_cnt_d  = '0;
        end else if (hd) begin
            pix_cnt_d = sat_inc(pix_cnt_q);
        end else if (line_end) begin
            line_len_d = pix_cnt_q;
            line_cnt_d = sat_inc(line_cnt_q);
            pix_cnt_d  = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge cmos_pclk or posedge rst) begin
        if (rst) begin
            href_pipe_q   <= '0;
            data_pipe_q   <= '0;
            v0_q          <= 1'b0;
            v1_q          <= 1'b0;
            armed_q       <= 1'b0;
            skip_cnt_q    <= '0;
            frame_valid_q <= 1'b0;
            vsync_pulse_q <= 1'b0;
            hd_prev_q     <= 1'b0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
        end else begin
            href_pipe_q   <= href_pipe_d;
            data_pipe_q   <= data_pipe_d;
            v0_q          <= v0_d;
            v1_q          <= v1_d;
            armed_q       <= armed_d;
            skip_cnt_q    <= skip_cnt_d;
            frame_valid_q <= frame_valid_d;
            vsync_pulse_q <= vsync_pulse_d;
            hd_prev_q     <= hd_prev_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cmos_href_delay = hd && frame_valid_q;
    assign cmos_data_delay = data_pipe_q[DELAY-1];
    assign vsync_pulse     = vsync_pulse_q;
    assign frame_valid     = frame_valid_q;
    assign pix_cnt         = pix_cnt_q;
    assign line_cnt        = line_cnt_q;
    assign line_len        = line_len_q;
    assign frame_lines     = frame_lines_q;

endmodule

// File: tb/tb_cmos_frame_align.sv
// -----------------------------------------------------------------------------
// Bench for cmos_frame_align. Two instances share one stimulus stream:
//   A: DELAY=2, rising-edge frame start, keep 1 of every 3 frames, 12-bit counters
//   B: DELAY=5, falling-edge frame start, keep all frames, 4-bit counters
// A cycle-level reference model derived from the frame/line rules predicts
// every output after every clock edge.
// -----------------------------------------------------------------------------
module tb_cmos_frame_align;

    localparam int DW     = 16;
    localparam int A_D    = 2;
    localparam int A_POL  = 1;
    localparam int A_SKIP = 2;
    localparam int A_CW   = 12;
    localparam int B_D    = 5;
    localparam int B_POL  = 0;
    localparam int B_SKIP = 0;
    localparam int B_CW   = 4;
    localparam int HMAX   = 16384;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          href = 1'b0;
    logic          vs = 1'b0;
    logic [DW-1:0] data = '0;

    always #5 clk = ~clk;

    logic            a_hrefd, a_pulse, a_fv;
    logic [DW-1:0]   a_data;
    logic [A_CW-1:0] a_pix, a_lines, a_llen, a_flines;
    logic            b_hrefd, b_pulse, b_fv;
    logic [DW-1:0]   b_data;
    logic [B_CW-1:0] b_pix, b_lines, b_llen, b_flines;

    cmos_frame_align #(.DATA_W(DW), .DELAY(A_D), .VS_POL(A_POL),
                       .FRAME_SKIP(A_SKIP), .CNT_W(A_CW)) dut_a (
        .cmos_pclk(clk), .rst(rst), .cmos_href(href), .cmos_vsync(vs),
        .cmos_data(data), .cmos_href_delay(a_hrefd), .cmos_data_delay(a_data),
        .vsync_pulse(a_pulse), .frame_valid(a_fv), .pix_cnt(a_pix),
        .line_cnt(a_lines), .line_len(a_llen), .frame_lines(a_flines));

    cmos_frame_align #(.DATA_W(DW), .DELAY(B_D), .VS_POL(B_POL),
                       .FRAME_SKIP(B_SKIP), .CNT_W(B_CW)) dut_b (
        .cmos_pclk(clk), .rst(rst), .cmos_href(href), .cmos_vsync(vs),
        .cmos_data(data), .cmos_href_delay(b_hrefd), .cmos_data_delay(b_data),
        .vsync_pulse(b_pulse), .frame_valid(b_fv), .pix_cnt(b_pix),
        .line_cnt(b_lines), .line_len(b_llen), .frame_lines(b_flines));

    // ---------------------------------------------------------------- checking
    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------- model
    string nm[2]    = '{"A", "B"};
    int    m_d[2]   = '{A_D, B_D};
    int    m_pol[2] = '{A_POL, B_POL};
    int    m_skip[2] = '{A_SKIP, B_SKIP};
    int    m_max[2] = '{(1 << A_CW) - 1, (1 << B_CW) - 1};

    int            cyc;                 // clock edges since reset release
    logic          hist_h[HMAX];
    logic          hist_v[HMAX];
    logic [DW-1:0] hist_d[HMAX];

    int            frame_num[2];        // frame edges seen since reset
    int            pix[2], lines[2], llen[2], flines[2];
    bit            fv[2], pulse[2];
    bit            pend_e[2], pend_h[2], pend_hp[2];
    bit            exp_h[2];
    logic [DW-1:0] exp_d[2];

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        cyc       = 0;
        hist_h[0] = 1'b0;
        hist_v[0] = 1'b0;
        hist_d[0] = '0;
        for (int i = 0; i < 2; i++) begin
            frame_num[i] = 0;
            pix[i] = 0; lines[i] = 0; llen[i] = 0; flines[i] = 0;
            fv[i] = 0; pulse[i] = 0;
            pend_e[i] = 0; pend_h[i] = 0; pend_hp[i] = 0;
            exp_h[i] = 0; exp_d[i] = '0;
        end
    endtask

    // Advance the model by one clock edge using the inputs just sampled.
    task automatic model_step();
        int  src;
        bit  e, h, le, cur_v, prev_v, hd_new;
        cyc++;
        hist_h[cyc] = href;
        hist_v[cyc] = vs;
        hist_d[cyc] = data;
        for (int i = 0; i < 2; i++) begin
            // registered effects of the conditions visible in the last cycle
            e  = pend_e[i];
            h  = pend_h[i];
            le = !h && pend_hp[i];
            pulse[i] = 0;
            if (e) begin
                frame_num[i]++;
                fv[i]    = ((frame_num[i] - 1) % (m_skip[i] + 1)) == 0;
                pulse[i] = fv[i];
                if (le) llen[i] = pix[i];
                flines[i] = le ? sat(lines[i] + 1, m_max[i]) : lines[i];
                lines[i]  = 0;
                pix[i]    = 0;
            end else if (h) begin
                pix[i] = sat(pix[i] + 1, m_max[i]);
            end else if (le) begin
                llen[i]  = pix[i];
                lines[i] = sat(lines[i] + 1, m_max[i]);
                pix[i]   = 0;
            end
            // delay line: the sample taken DELAY-1 edges ago reaches the output
            src      = cyc - m_d[i] + 1;
            hd_new   = (src >= 1) ? hist_h[src] : 1'b0;
            exp_d[i] = (src >= 1) ? hist_d[src] : '0;
            exp_h[i] = hd_new && fv[i];
            pend_hp[i] = pend_h[i];
            pend_h[i]  = hd_new;
            cur_v  = hist_v[cyc];
            prev_v = hist_v[cyc-1];
            pend_e[i] = (cur_v == m_pol[i][0]) && (prev_v != m_pol[i][0]);
        end
    endtask

    task automatic compare_all();
        check_eq({nm[0], ".href_delay"}, a_hrefd, exp_h[0]);
        check_eq({nm[0], ".data_delay"}, a_data, exp_d[0]);
        check_eq({nm[0], ".vsync_pulse"}, a_pulse, pulse[0]);
        check_eq({nm[0], ".frame_valid"}, a_fv, fv[0]);
        check_eq({nm[0], ".pix_cnt"}, a_pix, pix[0]);
        check_eq({nm[0], ".line_cnt"}, a_lines, lines[0]);
        check_eq({nm[0], ".line_len"}, a_llen, llen[0]);
        check_eq({nm[0], ".frame_lines"}, a_flines, flines[0]);
        check_eq({nm[1], ".href_delay"}, b_hrefd, exp_h[1]);
        check_eq({nm[1], ".data_delay"}, b_data, exp_d[1]);
        check_eq({nm[1], ".vsync_pulse"}, b_pulse, pulse[1]);
        check_eq({nm[1], ".frame_valid"}, b_fv, fv[1]);
        check_eq({nm[1], ".pix_cnt"}, b_pix, pix[1]);
        check_eq({nm[1], ".line_cnt"}, b_lines, lines[1]);
        check_eq({nm[1], ".line_len"}, b_llen, llen[1]);
        check_eq({nm[1], ".frame_lines"}, b_flines, flines[1]);
    endtask

    task automatic compare_zero(input string tag);
        check_eq({tag, ".A.href_delay"}, a_hrefd, 0);
        check_eq({tag, ".A.data_delay"}, a_data, 0);
        check_eq({tag, ".A.vsync_pulse"}, a_pulse, 0);
        check_eq({tag, ".A.frame_valid"}, a_fv, 0);
        check_eq({tag, ".A.pix_cnt"}, a_pix, 0);
        check_eq({tag, ".A.line_cnt"}, a_lines, 0);
        check_eq({tag, ".A.line_len"}, a_llen, 0);
        check_eq({tag, ".A.frame_lines"}, a_flines, 0);
        check_eq({tag, ".B.href_delay"}, b_hrefd, 0);
        check_eq({tag, ".B.data_delay"}, b_data, 0);
        check_eq({tag, ".B.vsync_pulse"}, b_pulse, 0);
        check_eq({tag, ".B.frame_valid"}, b_fv, 0);
        check_eq({tag, ".B.pix_cnt"}, b_pix, 0);
        check_eq({tag, ".B.line_cnt"}, b_lines, 0);
        check_eq({tag, ".B.line_len"}, b_llen, 0);
        check_eq({tag, ".B.frame_lines"}, b_flines, 0);
    endtask

    // --------------------------------------------------------------- stimulus
    // Entered away from the rising edge; drives inputs, waits one edge,
    // checks, and returns at the following falling edge.
    task automatic tick(input logic h, input logic v, input logic [DW-1:0] d);
        href = h;
        vs   = v;
        data = d;
        @(posedge clk);
        #1;
        if (cyc < HMAX - 1) begin
            model_step();
            compare_all();
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, DW'($urandom));
    endtask

    task automatic line(input int len);
        repeat (len) tick(1'b1, 1'b0, DW'($urandom));
    endtask

    task automatic vsync_high(input int w);
        repeat (w) tick(1'b0, 1'b1, DW'($urandom));
    endtask

    // Frame: vsync pulse, then lines; last line is followed by end_gap idle cycles.
    task automatic frame(input int nl, input int lo, input int hi, input int end_gap);
        vsync_high($urandom_range(1, 3));
        idle($urandom_range(1, 4));
        for (int l = 0; l < nl; l++) begin
            line($urandom_range(lo, hi));
            idle((l == nl - 1) ? end_gap : $urandom_range(1, 5));
        end
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare_zero("reset");
        rst = 1'b0;

        // href bursts before any frame edge: href_delay stays low
        for (int b = 0; b < 3; b++) begin
            line($urandom_range(4, 12));
            idle(3);
        end
        tick(1'b0, 1'b0, 16'hA5A5);
        idle(6);

        // 4 x 640 frame; vsync rising one cycle after the last href, 3 wide,
        // so the next frame edge lands on the last line end in both instances
        vsync_high(2);
        idle(3);
        for (int l = 0; l < 4; l++) begin
            line(640);
            idle((l == 3) ? 1 : 8);
        end
        vsync_high(3);
        idle(4);

        for (int f = 0; f < 12; f++)
            frame($urandom_range(0, 4), 3, 40, $urandom_range(0, 3));
        frame(0, 1, 1, 2);
        frame(0, 1, 1, 2);
        frame(2, 20, 20, 1);
        vsync_high(3);
        idle(3);

        // reset asserted mid-line, away from any clock edge
        vsync_high(2);
        idle(2);
        for (int g = 0; g < 1000 && pix[0] < 300; g++)
            tick(1'b1, 1'b0, DW'($urandom));
        check_eq("pre_reset.A.pix_cnt", a_pix, 300);
        #2 rst = 1'b1;
        #1 compare_zero("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // line with no preceding frame edge stays dropped
        line(50);
        idle(5);
        for (int f = 0; f < 5; f++)
            frame($urandom_range(1, 3), 3, 30, $urandom_range(0, 3));
        vsync_high(3);
        idle(8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
